// File: rtl/ntt_sdf_pkg.sv
// ntt_sdf_pkg: shared sizes and twiddle index helpers for the 64-point SDF NTT
package ntt_sdf_pkg;
  localparam int LOG_N = 6;
  localparam int N = 1 << LOG_N;
  localparam int DATA_W = 64;
  localparam int NUM_TW = N - 1;
  function automatic logic [LOG_N-1:0] tw_index(input int stage, input logic [LOG_N-1:0] n);
    logic [LOG_N-1:0] base;
    base = LOG_N'((1 << stage) - 1);
    return base + (n >> (LOG_N - stage));
  endfunction
  function automatic logic bf_phase(input int stage, input logic [LOG_N-1:0] n);
    logic [LOG_N-1:0] t;
    t = n >> (LOG_N - 1 - stage);
    return t[0];
  endfunction
endpackage

// File: rtl/sdf_stage_tw_ctr.sv
// sdf_stage_tw_ctr: sample counter and registered twiddle select for one SDF stage
module sdf_stage_tw_ctr import ntt_sdf_pkg::*; #(
  parameter int STAGE = 0,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W*NUM_TW-1:0] psi_in,
  input  logic                     valid,
  input  logic                     sof,
  output logic [DATA_W-1:0]        tw,
  output logic                     bf,
  output logic                     vld,
  output logic                     done
);
  localparam int PW = $clog2(DATA_W * NUM_TW);
  logic [LOG_N-1:0] cnt_q, cnt_d, n, k;
  logic [PW-1:0] base;
  logic ph;
  logic [DATA_W-1:0] tw_q, tw_d;
  logic bf_q, bf_d, vld_q, vld_d, done_q, done_d;
  always_comb begin
    n = sof ? '0 : cnt_q;
    ph = bf_phase(STAGE, n);
    k = tw_index(STAGE, n);
    base = PW'(k) * PW'(DATA_W);
    cnt_d = valid ? n + 1'b1 : cnt_q;
    vld_d = valid;
    bf_d = valid & ph;
    tw_d = (valid & ph) ? psi_in[base +: DATA_W] : '0;
    done_d = valid & (&n);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tw_q <= '0;
      bf_q <= 1'b0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tw_q <= tw_d;
      bf_q <= bf_d;
      vld_q <= vld_d;
      done_q <= done_d;
    end
  end
  assign tw = tw_q;
  assign bf = bf_q;
  assign vld = vld_q;
  assign done = done_q;
endmodule

// File: rtl/sdf_tw_sequencer.sv
// sdf_tw_sequencer: per-cycle twiddle and butterfly-phase selection for every SDF stage
module sdf_tw_sequencer import ntt_sdf_pkg::*; #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_W*(2**ADDR_W-1)-1:0]  psi_in,
  input  logic [ADDR_W-1:0]                st_valid,
  input  logic [ADDR_W-1:0]                st_sof,
  output logic [ADDR_W*DATA_W-1:0]         tw_out,
  output logic [ADDR_W-1:0]                bf_sel,
  output logic [ADDR_W-1:0]                tw_valid,
  output logic [ADDR_W-1:0]                frame_done
);
  for (genvar s = 0; s < ADDR_W; s++) begin : g_stage
    sdf_stage_tw_ctr #(.STAGE(s), .DATA_W(DATA_W)) u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .psi_in (psi_in),
      .valid  (st_valid[s]),
      .sof    (st_sof[s]),
      .tw     (tw_out[DATA_W*s +: DATA_W]),
      .bf     (bf_sel[s]),
      .vld    (tw_valid[s]),
      .done   (frame_done[s])
    );
  end
endmodule

// File: tb/tb_sdf_tw_sequencer.sv
// tb_sdf_tw_sequencer: scoreboard bench for the SDF twiddle sequencer
module tb_sdf_tw_sequencer;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int NT = 63;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW*NT-1:0] psi_in;
  logic [AW-1:0] st_valid = '0;
  logic [AW-1:0] st_sof = '0;
  logic [AW*DW-1:0] tw_out;
  logic [AW-1:0] bf_sel, tw_valid, frame_done;
  logic [DW-1:0] psi_m [NT];
  typedef struct {
    logic [AW*DW-1:0] tw;
    logic [AW-1:0] bf;
    logic [AW-1:0] vld;
    logic [AW-1:0] done;
  } exp_t;
  exp_t sb [$];
  int mcnt [AW];
  int n_cmp = 0;
  int n_err = 0;
  int done0 = 0;

  always #5 clk = ~clk;

  sdf_tw_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psi_in     (psi_in),
    .st_valid   (st_valid),
    .st_sof     (st_sof),
    .tw_out     (tw_out),
    .bf_sel     (bf_sel),
    .tw_valid   (tw_valid),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [AW-1:0] v, input logic [AW-1:0] sof);
    exp_t e;
    int n, k, bf;
    st_valid = v;
    st_sof = sof;
    e.tw = '0;
    e.bf = '0;
    e.vld = v;
    e.done = '0;
    for (int s = 0; s < AW; s++) begin
      n = sof[s] ? 0 : mcnt[s];
      if (v[s]) begin
        bf = (n >> (AW - 1 - s)) & 1;
        k = (1 << s) - 1 + (n >> (AW - s));
        e.bf[s] = bf[0];
        if (bf == 1) e.tw[DW*s +: DW] = psi_m[k];
        e.done[s] = (n == 63);
        mcnt[s] = (n + 1) % 64;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (frame_done[0]) done0++;
    check("tw_valid", tw_valid, e.vld);
    check("bf_sel", bf_sel, e.bf);
    check("frame_done", frame_done, e.done);
    for (int s = 0; s < AW; s++)
      check($sformatf("tw_out%0d", s), tw_out[DW*s +: DW], e.tw[DW*s +: DW]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"}, tw_valid, 0);
    check({tag, "_bf"}, bf_sel, 0);
    check({tag, "_done"}, frame_done, 0);
    for (int s = 0; s < AW; s++) check($sformatf("%s_tw%0d", tag, s), tw_out[DW*s +: DW], 0);
  endtask

  initial begin
    for (int k = 0; k < NT; k++) psi_m[k] = {$urandom, $urandom} | 64'h1;
    psi_m[0] = 64'h0AA4;
    psi_m[1] = 64'h014A;
    psi_m[2] = 64'h00F3;
    psi_m[31] = 64'h10CA;
    psi_m[32] = 64'h0774;
    psi_m[62] = 64'h1284;
    for (int k = 0; k < NT; k++) psi_in[DW*k +: DW] = psi_m[k];
    for (int s = 0; s < AW; s++) mcnt[s] = 0;
    for (int i = 0; i < 4; i++) begin
      st_valid = AW'($urandom);
      st_sof = AW'($urandom);
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    st_valid = '0;
    st_sof = '0;
    @(negedge clk);
    rst_n = 1'b1;
    // stage 0 alone: one frame starting with sof
    done0 = 0;
    for (int i = 0; i < 64; i++) step(6'b000001, i == 0 ? 6'b000001 : 6'b0);
    check("s0_done_pulses", done0, 1);
    // all stages together, with literal spot checks against the loaded table
    for (int i = 0; i < 64; i++) begin
      step(6'h3F, i == 0 ? 6'h3F : 6'h0);
      if (i == 40) check("s0_n40", tw_out[0 +: DW], 64'h0AA4);
      if (i == 20) check("s1_n20", tw_out[DW +: DW], 64'h014A);
      if (i == 50) check("s1_n50", tw_out[DW +: DW], 64'h00F3);
      if (i == 1) check("s5_n1", tw_out[5*DW +: DW], 64'h10CA);
      if (i == 3) check("s5_n3", tw_out[5*DW +: DW], 64'h0774);
      if (i == 63) check("s5_n63", tw_out[5*DW +: DW], 64'h1284);
      if (i == 10) check("s5_even_bf", 64'(bf_sel[5]), 0);
    end
    // stage 2 with 3-cycle valid gaps
    for (int i = 0; i < 64; i++) begin
      step(6'b000100, i == 0 ? 6'b000100 : 6'b0);
      repeat (3) step(6'b0, 6'b0);
    end
    // two frames back to back without sof: seamless wrap
    for (int i = 0; i < 128; i++) step(6'h3F, 6'h0);
    // stage 4 at an offset, stage 3 realigned mid-frame
    for (int i = 0; i < 7; i++) step(6'b010000, 6'b0);
    for (int i = 0; i < 60; i++) step(6'b011000, i == 20 ? 6'b001000 : 6'b0);
    // random traffic with occasional sof on any stage
    for (int i = 0; i < 300; i++)
      step(AW'($urandom), ($urandom_range(0, 15) == 0) ? AW'($urandom) : 6'b0);
    // async reset mid-frame while outputs are active
    step(6'b000001, 6'b000001);
    for (int i = 0; i < 40; i++) step(6'b000001, 6'b0);
    check("pre_rst_bf0", 64'(bf_sel[0]), 1);
    st_valid = '0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    for (int s = 0; s < AW; s++) mcnt[s] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step(6'h3F, 6'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdf_tw_sequencer.md
Name: sdf_tw_sequencer

Overview:
- Per-cycle twiddle selector for the 64-point SDF NTT pipeline.
- Sits directly downstream of tw_factor_rom and consumes its flattened psi_out bus (63 entries, rom index 0..62 = psi index 1..63).
- Tracks the sample position of every SDF stage and registers the twiddle that each stage's butterfly multiplier needs on that cycle, together with the butterfly-phase flag.
- One instance serves all LOG_N stages.

Parameters:
- ADDR_W, 6, log2 of NTT size N (LOG_N); number of stages.
- DATA_W, 64, twiddle/coefficient width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psi_in  in  DATA_W*(2**ADDR_W-1)  flattened twiddle table; entry k occupies bits [DATA_W*(k+1)-1 : DATA_W*k].
- st_valid  in  ADDR_W  bit s: stage s accepts a sample this cycle.
- st_sof  in  ADDR_W  bit s: the accepted sample is index 0 of a frame. Sampled only when st_valid[s]=1.
- tw_out  out  ADDR_W*DATA_W  slice s is the twiddle for stage s.
- bf_sel  out  ADDR_W  bit s: stage s is in butterfly phase (delay line full).
- tw_valid  out  ADDR_W  bit s: tw_out slice s and bf_sel[s] are valid.
- frame_done  out  ADDR_W  bit s: 1-cycle pulse when stage s consumes sample N-1.

Behaviour:
- Reset (async, rst_n=0): all per-stage counters=0; tw_out, bf_sel, tw_valid and frame_done all 0. Release is synchronous to clk.
- Each stage s owns an ADDR_W-bit counter cnt[s]. The sample index n used in cycle t is:
  - 0 if st_sof[s]=1,
  - otherwise cnt[s].
- On st_valid[s]=1: cnt[s] <= n+1 mod N, so it wraps 63 -> 0 with no stall. With st_valid[s]=0 the counter holds.
- st_sof[s] mid-frame forces realignment: the current sample is treated as index 0 and the next as index 1.
- Butterfly flag: bf = bit (ADDR_W-1-s) of n.
- Group: g = n >> (ADDR_W-s), using zero-extended arithmetic.
- Twiddle index: k = 2^s - 1 + g, always within 0..62. No range check is needed; the RTL must not index entry 63.
- Latency is 1 cycle, registered at clk edge t+1:
  - tw_valid[s] <= st_valid[s]
  - bf_sel[s] <= st_valid[s] & bf
  - tw_out slice s <= (st_valid[s] & bf) ? psi_in[k] : 0
  - frame_done[s] <= st_valid[s] & (n == N-1)
- Stages are fully independent. Different stages may be in different frames or positions, and may have simultaneous valid/sof.
- psi_in is treated as static. A change is reflected on the next registered output with no flush.
- Reset mid-frame discards position. The next frame must start with st_sof, or is assumed to start at index 0.
- No backpressure: the stage controller gates st_valid itself.

Decomposition:
- Package ntt_sdf_pkg:
  - LOG_N=6, N=64, DATA_W=64
  - NUM_TW = N-1
  - function tw_index(stage, n) returning 2^stage - 1 + (n >> (LOG_N-stage))
  - function bf_phase(stage, n)
- Sub-module sdf_stage_tw_ctr (parameter STAGE) holds the counter, sof/wrap logic, index calculation and output registers for one stage. The top generates ADDR_W instances sharing psi_in.

Test Plan:
- Reset: hold rst_n=0, toggle st_valid -> all outputs 0. Assert rst_n low asynchronously mid-cycle -> outputs clear before the next edge.
- Stage 0 frame with psi_in from tw_factor_rom, sof at n=0, 64 valid cycles:
  - n=0..31 -> bf_sel[0]=0, tw_out[0]=0.
  - n=32..63 -> bf_sel[0]=1, tw_out[0]=0x0AA4.
  - frame_done[0] pulses once, 1 cycle after n=63.
- Stage 1 frame:
  - n=16..31 -> 0x014A.
  - n=48..63 -> 0x00F3.
  - n=0..15 and n=32..47 -> bf_sel[1]=0.
- Stage 5 frame:
  - n=1 -> 0x10CA (k=31).
  - n=3 -> 0x0AE0? no: n=3 -> k=32 -> 0x0774.
  - n=63 -> 0x1284 (k=62).
  - Every even n -> bf_sel[5]=0.
- Stalls and wrap: stage 2 with valid gaps of 3 cycles -> counter holds, and the index sequence is identical to the gapless run. Running 2 frames back-to-back without sof -> wrap 63 -> 0 is seamless.
- Mid-frame sof and independence: stage 3 at n=20 gets sof -> next outputs follow n=0,1,... Meanwhile stage 4 is driven concurrently at a different offset and its outputs remain correct.
